vec_mac_feeder: RTL
===================

VEC_MAC_FEEDER -- requirements
Module: vec_mac_feeder

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the uint8 lanes per output beat.
REQ-002 SHALL have parameter BEATS, default 250, giving the beats per MAC window (LANES*BEATS = 1000 elements).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1 bit: an upstream element pair is present.
REQ-006 SHALL have port s_ready, output, 1 bit: the feeder accepts an element pair this cycle.
REQ-007 SHALL have port s_a, input, 8 bits: element of vector A, unsigned.
REQ-008 SHALL have port s_b, input, 8 bits: element of vector B, unsigned.
REQ-009 SHALL have port s_last, input, 1 bit: the current pair is the last element of the vector.
REQ-010 SHALL have port m_valid, output, 1 bit: drives in_valid of vector_mac_top.
REQ-011 SHALL have port m_a, output, 32 bits: packed A beat, drives in_a.
REQ-012 SHALL have port m_b, output, 32 bits: packed B beat, drives in_b.
REQ-013 SHALL have port vec_done, output, 1 bit: pulses for one cycle with the final (BEATS-th) beat of a window.
REQ-014 SHALL have port ovf_err, output, 1 bit: sticky flag, set when elements are dropped.

Function
REQ-015 SHALL accept a pair only on a cycle where s_valid and s_ready are both high.
REQ-016 SHALL pack elements by lane, lane 0 first: element k goes to bits [8k+7:8k] of m_a and m_b, so m_a = {a3,a2,a1,a0}.
REQ-017 SHALL assert m_valid, registered, in the cycle after the LANES-th accepted pair of a beat, or after a pair accepted with s_last=1.
REQ-018 SHALL hold m_a and m_b stable whenever m_valid is low, and SHALL drive m_valid for exactly one cycle per beat.
REQ-019 SHALL zero-fill the unused upper lanes of a partial beat that is closed by s_last.
REQ-020 SHALL keep a beat counter running 0..BEATS-1 and a lane counter running 0..LANES-1, and both SHALL wrap to 0 at the end of each window.
REQ-021 SHALL implement the state machine FILL -> PAD -> FILL: in FILL, s_ready=1; when s_last is accepted and beats emitted < BEATS, go to PAD.
REQ-022 SHALL, in PAD, hold s_ready=0 and emit all-zero beats (m_a=m_b=0), one per cycle, until BEATS beats have been emitted, then return to FILL.
REQ-023 SHALL, in FILL, go to DROP when the BEATS-th beat completes without s_last being seen.
REQ-024 SHALL, in DROP, hold s_ready=1, discard pairs, set ovf_err, and return to FILL after the pair carrying s_last is accepted.
REQ-025 SHALL treat s_last on the 1000th element as a normal window end: no PAD state, no error.
REQ-026 SHALL permit back-to-back windows with no idle cycle: the first pair of the next vector is accepted in the cycle after the window's final beat.
REQ-027 SHALL assert vec_done coincident with m_valid on beat BEATS-1 only.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set m_valid=0, vec_done=0, ovf_err=0, m_a=0, m_b=0, s_ready=0, both counters to 0, and state to FILL.
REQ-029 SHALL drive s_ready=1 in the first cycle after rst is deasserted.
REQ-030 SHALL, on reset mid-window, discard the partial beat and emit no further beats for that vector.

Structure
REQ-031 SHALL take LANES, BEATS and the state encoding (FILL, PAD, DROP) from a shared package, vec_mac_pkg, which vector_mac_top also uses.
REQ-032 SHALL be a single module with no sub-module; the lane-packing shifter is inline.

Verification
REQ-033 SHALL be verified for: 1000 pairs of a=b=0xFF with s_last on pair 1000 -> 250 beats of 0xFFFFFFFF, vec_done on beat 250, and MAC result 65,025,000.
REQ-034 SHALL be verified for: 5 pairs a=b=1,2,3,4,5 with s_last on pair 5 -> beat0 m_a=0x04030201, beat1 m_a=0x00000005, then 248 zero beats, with s_ready=0 during padding, and MAC result 55.
REQ-035 SHALL be verified for: 1003 pairs of a=b=1 with s_last on pair 1003 -> exactly 250 beats, MAC result 1000, and ovf_err=1.
REQ-036 SHALL be verified for: rst pulsed after 37 accepted pairs, then a new 4-pair vector of a=b=2 -> no stale beats, 250 beats, and MAC result 16.
REQ-037 SHALL be verified for: two back-to-back 1000-pair vectors with random s_valid gaps -> 500 beats, two vec_done pulses, and each MAC result equal to the software dot product.

Source files
------------

// File: rtl/vec_mac_pkg.sv
// vec_mac_pkg: window geometry and feeder state encoding shared with vector_mac_top
package vec_mac_pkg;
    localparam int LANES = 4;
    localparam int BEATS = 250;
    typedef enum logic [1:0] {FILL, PAD, DROP} state_t;
endpackage

// File: rtl/vec_mac_feeder.sv
// vec_mac_feeder: packs uint8 pairs into LANES-wide beats, padding or dropping to exactly BEATS beats per window
module vec_mac_feeder #(
    parameter int LANES = vec_mac_pkg::LANES,
    parameter int BEATS = vec_mac_pkg::BEATS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_a,
    input  logic [7:0]         s_b,
    input  logic               s_last,
    output logic               m_valid,
    output logic [8*LANES-1:0] m_a,
    output logic [8*LANES-1:0] m_b,
    output logic               vec_done,
    output logic               ovf_err
);
    import vec_mac_pkg::*;
    localparam int W = 8 * LANES;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    state_t state, state_n;
    logic [LW-1:0] lane, lane_n;
    logic [BW-1:0] beat, beat_n;
    logic [W-1:0] acc_a, acc_b, acc_a_n, acc_b_n, pk_a, pk_b, m_a_n, m_b_n;
    logic fire, last_lane, last_beat, emit, ovf_n;
    assign s_ready = !rst && state != PAD;
    assign fire = s_valid && s_ready;
    assign last_lane = lane == LW'(LANES - 1);
    assign last_beat = beat == BW'(BEATS - 1);
    // lane 0 starts a fresh beat, so stale upper lanes never leak into a partial beat
    assign pk_a = (lane == '0 ? '0 : acc_a) | (W'(s_a) << {lane, 3'b000});
    assign pk_b = (lane == '0 ? '0 : acc_b) | (W'(s_b) << {lane, 3'b000});
    always_comb begin
        state_n = state;
        lane_n = lane;
        beat_n = beat;
        acc_a_n = acc_a;
        acc_b_n = acc_b;
        m_a_n = m_a;
        m_b_n = m_b;
        emit = 1'b0;
        ovf_n = ovf_err;
        if (state == PAD) begin
            emit = 1'b1;
            m_a_n = '0;
            m_b_n = '0;
            state_n = last_beat ? FILL : PAD;
        end else if (state == DROP) begin
            ovf_n = ovf_err || fire;
            state_n = fire && s_last ? FILL : DROP;
        end else if (fire) begin
            if (last_lane || s_last) begin
                emit = 1'b1;
                m_a_n = pk_a;
                m_b_n = pk_b;
                lane_n = '0;
                state_n = s_last && !last_beat ? PAD : !s_last && last_beat ? DROP : FILL;
            end else begin
                lane_n = lane + LW'(1);
                acc_a_n = pk_a;
                acc_b_n = pk_b;
            end
        end
        if (emit)
            beat_n = last_beat ? '0 : beat + BW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            lane <= '0;
            beat <= '0;
            acc_a <= '0;
            acc_b <= '0;
            m_a <= '0;
            m_b <= '0;
            m_valid <= 1'b0;
            vec_done <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            state <= state_n;
            lane <= lane_n;
            beat <= beat_n;
            acc_a <= acc_a_n;
            acc_b <= acc_b_n;
            m_a <= m_a_n;
            m_b <= m_b_n;
            m_valid <= emit;
            vec_done <= emit && last_beat;
            ovf_err <= ovf_n;
        end
    end
endmodule
